// File: rtl/top_level.sv
// Single-cycle 8-bit register machine: PC, 9-bit instruction ROM, 8x8 register file,
// ALU, 256x8 data memory and an 8-entry branch-target LUT.

module ProgramCounter #(
    parameter int IM_AW = 10
) (
    input  logic             CLK,
    input  logic             start,
    input  logic [IM_AW-1:0] pc_d_i,
    output logic [IM_AW-1:0] PC
);
    always_ff @(posedge CLK or posedge start) begin
        if (start) PC <= '0;
        else       PC <= pc_d_i;
    end
endmodule

module InstRom #(
    parameter int    IM_AW     = 10,
    parameter string PROG_FILE = "machine_code.txt"
) (
    input  logic [IM_AW-1:0] addr_i,
    output logic [8:0]       instr_o
);
    logic [8:0] rom [0:2**IM_AW-1];

    // Words the image does not cover read as 0, i.e. ADD R0,R0.
    initial begin
        for (int i = 0; i < 2**IM_AW; i++) rom[i[IM_AW-1:0]] = '0;
    end

    assign instr_o = rom[addr_i];
endmodule

module BranchLut #(
    parameter int    IM_AW    = 10,
    parameter string LUT_FILE = "branch_lut.txt"
) (
    input  logic [2:0]       sel_i,
    output logic [IM_AW-1:0] target_o
);
    logic [IM_AW-1:0] lut [0:7];

    initial begin
        for (int i = 0; i < 8; i++) lut[i[2:0]] = '0;
    end

    assign target_o = lut[sel_i];
endmodule

module RegFile (
    input  logic       CLK,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [2:0] raddr_a_i,
    input  logic [2:0] raddr_b_i,
    output logic [7:0] rdata_a_o,
    output logic [7:0] rdata_b_o
);
    logic [7:0] registers [0:7];

    // Deliberately no reset: contents survive start so preloaded values are kept.
    always_ff @(posedge CLK) begin
        if (we_i) registers[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = registers[raddr_a_i];
    assign rdata_b_o = registers[raddr_b_i];
endmodule

module DataMem (
    input  logic       CLK,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);
    logic [7:0] core [0:255];

    always_ff @(posedge CLK) begin
        if (we_i) core[addr_i] <= wdata_i;
    end

    assign rdata_o = core[addr_i];
endmodule

module Alu (
    input  logic [2:0] ALU_op_code,
    input  logic [2:0] func_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] ALU_out
);
    always_comb begin
        ALU_out = a_i;
        case (ALU_op_code)
            3'b000: ALU_out = a_i + b_i;
            3'b001: ALU_out = a_i - b_i;
            3'b010: ALU_out = a_i & b_i;
            3'b011: begin
                case (func_i)
                    3'b000:  ALU_out = a_i << 1;
                    3'b001:  ALU_out = a_i >> 1;
                    3'b010:  ALU_out = ~a_i;
                    default: ALU_out = a_i;
                endcase
            end
            3'b110:  ALU_out = a_i + {{5{func_i[2]}}, func_i};
            default: ALU_out = a_i;
        endcase
    end
endmodule

module top_level #(
    parameter int    IM_AW     = 10,
    parameter string PROG_FILE = "machine_code.txt",
    parameter string LUT_FILE  = "branch_lut.txt"
) (
    input  logic CLK,
    input  logic start,
    output logic halt
);
    logic [IM_AW-1:0] PC;
    logic [IM_AW-1:0] pc_d;
    logic [IM_AW-1:0] branch_target;
    logic [8:0]       Instruction;
    logic [2:0]       op;
    logic [2:0]       a_addr;
    logic [2:0]       b_addr;
    logic [7:0]       ra_data;
    logic [7:0]       rb_data;
    logic [7:0]       alu_result;
    logic [7:0]       mem_rdata;
    logic [7:0]       wb_data;
    logic             reg_we;
    logic             mem_we;

    assign op     = Instruction[8:6];
    assign a_addr = Instruction[5:3];
    assign b_addr = Instruction[2:0];

    assign halt = !start && (op == 3'b011) && (b_addr == 3'b111);

    // Only the arithmetic, load, ADDI and the three real SPECIAL ops write back.
    always_comb begin
        reg_we = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b110: reg_we = 1'b1;
            3'b011: reg_we = (b_addr == 3'b000) || (b_addr == 3'b001) || (b_addr == 3'b010);
            default: reg_we = 1'b0;
        endcase
        if (start) reg_we = 1'b0;
    end

    assign mem_we  = !start && (op == 3'b101);
    assign wb_data = (op == 3'b100) ? mem_rdata : alu_result;

    always_comb begin
        pc_d = PC + 1'b1;
        if (halt) pc_d = PC;
        else if ((op == 3'b111) && (ra_data != 8'd0)) pc_d = branch_target;
    end

    ProgramCounter #(.IM_AW(IM_AW)) PC1 (
        .CLK   (CLK),
        .start (start),
        .pc_d_i(pc_d),
        .PC    (PC)
    );

    InstRom #(.IM_AW(IM_AW), .PROG_FILE(PROG_FILE)) rom1 (
        .addr_i (PC),
        .instr_o(Instruction)
    );

    BranchLut #(.IM_AW(IM_AW), .LUT_FILE(LUT_FILE)) lut1 (
        .sel_i   (b_addr),
        .target_o(branch_target)
    );

    RegFile reg_file1 (
        .CLK      (CLK),
        .we_i     (reg_we),
        .waddr_i  (a_addr),
        .wdata_i  (wb_data),
        .raddr_a_i(a_addr),
        .raddr_b_i(b_addr),
        .rdata_a_o(ra_data),
        .rdata_b_o(rb_data)
    );

    Alu ALU1 (
        .ALU_op_code(op),
        .func_i     (b_addr),
        .a_i        (ra_data),
        .b_i        (rb_data),
        .ALU_out    (alu_result)
    );

    DataMem data_mem1 (
        .CLK    (CLK),
        .we_i   (mem_we),
        .addr_i (rb_data),
        .wdata_i(ra_data),
        .rdata_o(mem_rdata)
    );
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: single-instruction vector table plus short programs
// loaded hierarchically into ROM, LUT, register file and data memory.

module tb_top_level;
    localparam logic [8:0] HALT_INSTR = 9'b011_000_111;

    logic CLK;
    logic start;
    logic halt;
    int   checkCount = 0;
    int   passCount  = 0;

    typedef struct {
        logic [8:0] instr;
        logic [7:0] aVal;
        logic [7:0] bVal;
        logic [7:0] expRa;
        logic [9:0] expPc;
        logic       expHalt;
    } vec_t;

    vec_t vecs [13];

    top_level #(.IM_AW(10), .PROG_FILE(""), .LUT_FILE("")) dut (
        .CLK  (CLK),
        .start(start),
        .halt (halt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    endtask

    // Hold start, wipe the program and LUT, and lay down a known register/memory image.
    task automatic applyStimulus();
        @(negedge CLK);
        start = 1'b1;
        for (int i = 0; i < 1024; i++) dut.rom1.rom[10'(i)] = 9'd0;
        for (int i = 0; i < 8; i++) dut.lut1.lut[3'(i)] = 10'(100 + 7 * i);
        dut.lut1.lut[7] = 10'd1023;
        for (int i = 0; i < 8; i++) dut.reg_file1.registers[3'(i)] <= 8'd0;
        for (int i = 0; i < 256; i++) dut.data_mem1.core[8'(i)] <= 8'(i) ^ 8'h5A;
    endtask

    task automatic releaseStart();
        @(negedge CLK);
        start = 1'b0;
    endtask

    initial begin
        int edges;
        int badCount;

        start = 1'b1;
        #1;

        vecs[0]  = '{9'b000_001_010, 8'h70, 8'h95, 8'h05, 10'd1,   1'b1};
        vecs[1]  = '{9'b001_001_010, 8'h03, 8'h05, 8'hFE, 10'd1,   1'b1};
        vecs[2]  = '{9'b010_001_010, 8'hCA, 8'h5F, 8'h4A, 10'd1,   1'b1};
        vecs[3]  = '{9'b011_001_000, 8'hC3, 8'h00, 8'h86, 10'd1,   1'b1};
        vecs[4]  = '{9'b011_001_001, 8'hC3, 8'h00, 8'h61, 10'd1,   1'b1};
        vecs[5]  = '{9'b011_001_010, 8'h3C, 8'h00, 8'hC3, 10'd1,   1'b1};
        vecs[6]  = '{9'b011_001_011, 8'h77, 8'h12, 8'h77, 10'd1,   1'b1};
        vecs[7]  = '{9'b110_001_011, 8'hFE, 8'h00, 8'h01, 10'd1,   1'b1};
        vecs[8]  = '{9'b110_001_100, 8'h02, 8'h00, 8'hFE, 10'd1,   1'b1};
        vecs[9]  = '{9'b000_010_010, 8'h41, 8'h99, 8'h82, 10'd1,   1'b1};
        vecs[10] = '{9'b111_001_011, 8'h01, 8'h00, 8'h01, 10'd121, 1'b0};
        vecs[11] = '{9'b111_001_011, 8'h00, 8'h00, 8'h00, 10'd1,   1'b1};
        vecs[12] = '{9'b100_001_010, 8'h33, 8'h10, 8'h4A, 10'd1,   1'b1};

        for (int v = 0; v < 13; v++) begin
            applyStimulus();
            dut.rom1.rom[0] = vecs[v].instr;
            dut.rom1.rom[1] = HALT_INSTR;
            dut.reg_file1.registers[vecs[v].instr[2:0]] <= vecs[v].bVal;
            dut.reg_file1.registers[vecs[v].instr[5:3]] <= vecs[v].aVal;
            releaseStart();
            @(negedge CLK);
            checkOutput($sformatf("vec%0d_ra", v), 32'(dut.reg_file1.registers[vecs[v].instr[5:3]]), 32'(vecs[v].expRa));
            checkOutput($sformatf("vec%0d_pc", v), 32'(dut.PC), 32'(vecs[v].expPc));
            checkOutput($sformatf("vec%0d_halt", v), 32'(halt), 32'(vecs[v].expHalt));
        end

        // ALU program; preloads must survive the reset cycle, then an async reset mid-cycle.
        applyStimulus();
        dut.rom1.rom[0] = 9'b000_001_000;
        dut.rom1.rom[1] = 9'b110_001_111;
        dut.rom1.rom[2] = 9'b001_000_001;
        dut.rom1.rom[3] = HALT_INSTR;
        dut.reg_file1.registers[0] <= 8'd5;
        releaseStart();
        #1;
        checkOutput("reset_pc", 32'(dut.PC), 32'd0);
        checkOutput("reset_halt", 32'(halt), 32'd0);
        checkOutput("reset_keep_r0", 32'(dut.reg_file1.registers[0]), 32'd5);
        checkOutput("reset_keep_r1", 32'(dut.reg_file1.registers[1]), 32'd0);
        repeat (3) @(negedge CLK);
        checkOutput("alu_halt", 32'(halt), 32'd1);
        checkOutput("alu_pc", 32'(dut.PC), 32'd3);
        checkOutput("alu_r0", 32'(dut.reg_file1.registers[0]), 32'd1);
        checkOutput("alu_r1", 32'(dut.reg_file1.registers[1]), 32'd4);
        for (int r = 2; r < 8; r++)
            checkOutput($sformatf("alu_r%0d", r), 32'(dut.reg_file1.registers[3'(r)]), 32'd0);
        #3;
        start = 1'b1;
        #1;
        checkOutput("async_reset_pc", 32'(dut.PC), 32'd0);
        checkOutput("async_reset_halt", 32'(halt), 32'd0);

        // Store then load through R1.
        applyStimulus();
        dut.rom1.rom[0] = 9'b101_000_001;
        dut.rom1.rom[1] = 9'b100_010_001;
        dut.rom1.rom[2] = HALT_INSTR;
        dut.reg_file1.registers[0] <= 8'd5;
        releaseStart();
        repeat (2) @(negedge CLK);
        checkOutput("mem_halt", 32'(halt), 32'd1);
        checkOutput("mem_pc", 32'(dut.PC), 32'd2);
        checkOutput("mem_core0", 32'(dut.data_mem1.core[0]), 32'd5);
        checkOutput("mem_r2", 32'(dut.reg_file1.registers[2]), 32'd5);

        // Countdown loop, then halt persistence and restart.
        applyStimulus();
        dut.rom1.rom[0] = 9'b110_000_111;
        dut.rom1.rom[1] = 9'b111_000_000;
        dut.rom1.rom[2] = HALT_INSTR;
        dut.lut1.lut[0] = 10'd0;
        dut.reg_file1.registers[0] <= 8'd5;
        releaseStart();
        edges = 0;
        while (!halt && edges < 40) begin
            @(negedge CLK);
            edges++;
        end
        checkOutput("loop_edges", 32'(edges), 32'd10);
        checkOutput("loop_halt", 32'(halt), 32'd1);
        checkOutput("loop_pc", 32'(dut.PC), 32'd2);
        checkOutput("loop_r0", 32'(dut.reg_file1.registers[0]), 32'd0);
        repeat (5) @(negedge CLK);
        checkOutput("hold_halt", 32'(halt), 32'd1);
        checkOutput("hold_pc", 32'(dut.PC), 32'd2);
        badCount = 0;
        for (int r = 0; r < 8; r++)
            if (dut.reg_file1.registers[3'(r)] !== 8'd0) badCount++;
        checkOutput("hold_regs_bad", 32'(badCount), 32'd0);
        badCount = 0;
        for (int i = 0; i < 256; i++)
            if (dut.data_mem1.core[8'(i)] !== (8'(i) ^ 8'h5A)) badCount++;
        checkOutput("hold_mem_bad", 32'(badCount), 32'd0);
        start = 1'b1;
        #1;
        checkOutput("restart_halt", 32'(halt), 32'd0);
        checkOutput("restart_pc", 32'(dut.PC), 32'd0);

        // Wrap-around add and the SPECIAL shift/invert group.
        applyStimulus();
        dut.rom1.rom[0] = 9'b110_000_001;
        dut.rom1.rom[1] = 9'b011_001_000;
        dut.rom1.rom[2] = 9'b011_010_001;
        dut.rom1.rom[3] = 9'b011_011_010;
        dut.rom1.rom[4] = HALT_INSTR;
        dut.reg_file1.registers[0] <= 8'hFF;
        dut.reg_file1.registers[1] <= 8'h81;
        dut.reg_file1.registers[2] <= 8'h81;
        dut.reg_file1.registers[3] <= 8'h0F;
        releaseStart();
        repeat (4) @(negedge CLK);
        checkOutput("ws_halt", 32'(halt), 32'd1);
        checkOutput("ws_pc", 32'(dut.PC), 32'd4);
        checkOutput("ws_r0", 32'(dut.reg_file1.registers[0]), 32'h00);
        checkOutput("ws_r1", 32'(dut.reg_file1.registers[1]), 32'h02);
        checkOutput("ws_r2", 32'(dut.reg_file1.registers[2]), 32'h40);
        checkOutput("ws_r3", 32'(dut.reg_file1.registers[3]), 32'hF0);

        // Branch to the last ROM word and let the PC wrap to 0.
        applyStimulus();
        dut.rom1.rom[0] = 9'b111_000_111;
        dut.reg_file1.registers[0] <= 8'd1;
        releaseStart();
        @(negedge CLK);
        checkOutput("wrap_pc_top", 32'(dut.PC), 32'd1023);
        @(negedge CLK);
        checkOutput("wrap_pc_zero", 32'(dut.PC), 32'd0);
        checkOutput("wrap_r0", 32'(dut.reg_file1.registers[0]), 32'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
